// File: rtl/cp0_exc_unit_pkg.sv
// CP0 exception unit shared definitions: register numbers, field positions, ExcCodes.
package cp0_exc_unit_pkg;

  localparam int unsigned HWINT_W  = 6;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned EXC_W    = 5;

  localparam logic [DATA_W-1:0] PRID = 32'h0000_4D49;

  localparam logic [REG_W-1:0] REG_SR    = 5'd12;
  localparam logic [REG_W-1:0] REG_CAUSE = 5'd13;
  localparam logic [REG_W-1:0] REG_EPC   = 5'd14;
  localparam logic [REG_W-1:0] REG_PRID  = 5'd15;

  localparam int unsigned IM_HI  = 15;
  localparam int unsigned IM_LO  = 10;
  localparam int unsigned EXL    = 1;
  localparam int unsigned IE     = 0;
  localparam int unsigned BD_BIT = 31;
  localparam int unsigned EXC_HI = 6;
  localparam int unsigned EXC_LO = 2;

  localparam logic [EXC_W-1:0] EXC_INT = 5'd0;
  localparam logic [EXC_W-1:0] EXC_RI  = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV  = 5'd12;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline-to-CP0 bus: mfc0/mtc0 access, M-stage exception info and interrupt lines.
interface cp0_exc_unit_if;
  import cp0_exc_unit_pkg::*;

  logic [REG_W-1:0]   A1;
  logic [REG_W-1:0]   A2;
  logic [DATA_W-1:0]  DIn;
  logic               WE;
  logic [DATA_W-1:0]  PC;
  logic               BD;
  logic [EXC_W-1:0]   ExcCode_in;
  logic               error;
  logic [HWINT_W-1:0] HWInt;
  logic               EXLClr;
  logic               IntReq;
  logic [DATA_W-1:0]  EPC_out;
  logic [DATA_W-1:0]  DOut;

  modport master (
    output A1, A2, DIn, WE, PC, BD, ExcCode_in, error, HWInt, EXLClr,
    input  IntReq, EPC_out, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, PC, BD, ExcCode_in, error, HWInt, EXLClr,
    output IntReq, EPC_out, DOut
  );
endinterface

// File: rtl/cp0_int_arb.sv
// Interrupt vs exception arbitration; interrupt wins, nothing accepted while EXL is set.
module cp0_int_arb
  import cp0_exc_unit_pkg::*;
(
  input  logic               reset,
  input  logic [HWINT_W-1:0] hwint_i,
  input  logic [HWINT_W-1:0] im_i,
  input  logic               ie_i,
  input  logic               exl_i,
  input  logic               error_i,
  input  logic [EXC_W-1:0]   exc_code_i,
  output logic               int_req_o,
  output logic [EXC_W-1:0]   exc_code_o
);

  logic int_hit;
  logic exc_hit;

  assign int_hit    = (|(hwint_i & im_i)) & ie_i & ~exl_i;
  assign exc_hit    = error_i & ~exl_i;
  assign int_req_o  = ~reset & (int_hit | exc_hit);
  assign exc_code_o = int_hit ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: SR/Cause/EPC register file, mfc0 read mux, exception capture.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  cp0_exc_unit_if.slave  bus
);

  logic [HWINT_W-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic [EXC_W-1:0]   exc_q, exc_d;
  logic [DATA_W-1:0]  epc_q, epc_d;

  logic               int_req;
  logic [EXC_W-1:0]   exc_next;
  logic [DATA_W-1:0]  sr_word;
  logic [DATA_W-1:0]  cause_word;
  logic [DATA_W-1:0]  dout_c;

  cp0_int_arb u_arb (
    .reset      (reset),
    .hwint_i    (bus.HWInt),
    .im_i       (im_q),
    .ie_i       (ie_q),
    .exl_i      (exl_q),
    .error_i    (bus.error),
    .exc_code_i (bus.ExcCode_in),
    .int_req_o  (int_req),
    .exc_code_o (exc_next)
  );

  // Exception capture outranks mtc0; EXLClr outranks an SR write to EXL only.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = bus.HWInt;
    exc_d = exc_q;
    epc_d = epc_q;
    if (int_req) begin
      exl_d = 1'b1;
      exc_d = exc_next;
      bd_d  = bus.BD;
      epc_d = bus.BD ? (bus.PC - 32'd4) : bus.PC;
    end else begin
      if (bus.WE) begin
        case (bus.A2)
          REG_SR: begin
            im_d  = bus.DIn[IM_HI:IM_LO];
            exl_d = bus.DIn[EXL];
            ie_d  = bus.DIn[IE];
          end
          REG_EPC: epc_d = bus.DIn;
          default: ;
        endcase
      end
      if (bus.EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    sr_word                     = '0;
    sr_word[IM_HI:IM_LO]        = im_q;
    sr_word[EXL]                = exl_q;
    sr_word[IE]                 = ie_q;
    cause_word                  = '0;
    cause_word[BD_BIT]          = bd_q;
    cause_word[IM_HI:IM_LO]     = ip_q;
    cause_word[EXC_HI:EXC_LO]   = exc_q;
  end

  always_comb begin
    dout_c = '0;
    case (bus.A1)
      REG_SR:    dout_c = sr_word;
      REG_CAUSE: dout_c = cause_word;
      REG_EPC:   dout_c = epc_q;
      REG_PRID:  dout_c = PRID;
      default:   ;
    endcase
  end

  assign bus.IntReq  = int_req;
  assign bus.EPC_out = epc_q;
  assign bus.DOut    = dout_c;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit.
module tb_cp0_exc_unit;
  import cp0_exc_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cp0_exc_unit_if bus ();

  cp0_exc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = '0; bus.WE = 1'b0;
    bus.PC = '0; bus.BD = 1'b0; bus.ExcCode_in = '0; bus.error = 1'b0;
    bus.HWInt = '0; bus.EXLClr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.A1 = a;
    #1;
    d = bus.DOut;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle();
    reset = 1'b1;
    bus.error = 1'b1;
    bus.ExcCode_in = EXC_OV;
    #1;
    checks++;
    if (bus.IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq: got %b want 0", bus.IntReq); end
    tick(); tick();
    checks++;
    if (bus.IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq2: got %b want 0", bus.IntReq); end
    rd(5'd12, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_sr: got %h want 0", d); end
    rd(5'd13, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h want 0", d); end
    rd(5'd14, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", d); end
    rd(5'd15, d); checks++;
    if (d !== 32'h0000_4D49) begin errors++; $display("FAIL reset_prid: got %h want 00004d49", d); end
    rd(5'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL other_reg: got %h want 0", d); end
    bus.error = 1'b0;
    bus.ExcCode_in = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    idle();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    tick();
    idle();
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_0401) begin errors++; $display("FAIL int_sr_write: got %h want 00000401", d); end
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_1000;
    #1; checks++;
    if (bus.IntReq !== 1'b1) begin errors++; $display("FAIL int_req: got %b want 1", bus.IntReq); end
    tick();
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0400) begin errors++; $display("FAIL int_cause: got %h want 00000400", d); end
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_0403) begin errors++; $display("FAIL int_sr_exl: got %h want 00000403", d); end
    checks++;
    if (bus.EPC_out !== 32'h0000_1000) begin errors++; $display("FAIL int_epc: got %h want 00001000", bus.EPC_out); end
    checks++;
    if (bus.IntReq !== 1'b0) begin errors++; $display("FAIL int_req_exl: got %b want 0", bus.IntReq); end
    bus.HWInt = 6'b0; bus.EXLClr = 1'b1;
    tick();
    idle();
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_0401) begin errors++; $display("FAIL int_eret: got %h want 00000401", d); end
  endtask

  task automatic test_exception_bd();
    logic [31:0] d;
    idle();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0000;
    tick();
    idle();
    bus.error = 1'b1; bus.ExcCode_in = EXC_RI; bus.BD = 1'b1; bus.PC = 32'h0000_3008;
    #1; checks++;
    if (bus.IntReq !== 1'b1) begin errors++; $display("FAIL exc_req: got %b want 1", bus.IntReq); end
    tick();
    checks++;
    if (bus.EPC_out !== 32'h0000_3004) begin errors++; $display("FAIL exc_epc: got %h want 00003004", bus.EPC_out); end
    rd(5'd13, d); checks++;
    if (d !== 32'h8000_0028) begin errors++; $display("FAIL exc_cause: got %h want 80000028", d); end
    checks++;
    if (bus.IntReq !== 1'b0) begin errors++; $display("FAIL exc_ignored_exl: got %b want 0", bus.IntReq); end
    bus.error = 1'b0; bus.EXLClr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_priority();
    logic [31:0] d;
    idle();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    tick();
    idle();
    bus.HWInt = 6'b000001; bus.error = 1'b1; bus.ExcCode_in = EXC_OV; bus.PC = 32'h0000_2040;
    #1; checks++;
    if (bus.IntReq !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", bus.IntReq); end
    tick();
    idle();
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause: got %h want 00000400", d); end
  endtask

  task automatic test_exlclr_write();
    logic [31:0] d;
    idle();
    bus.EXLClr = 1'b1; bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC03;
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_0403) begin errors++; $display("FAIL no_bypass: got %h want 00000403", d); end
    tick();
    idle();
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_FC01) begin errors++; $display("FAIL exlclr_prio: got %h want 0000fc01", d); end
  endtask

  task automatic test_drop_mtc0();
    logic [31:0] d;
    idle();
    bus.HWInt = 6'b100000; bus.PC = 32'h0000_2000;
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hDEAD_BEEC;
    #1; checks++;
    if (bus.IntReq !== 1'b1) begin errors++; $display("FAIL drop_req: got %b want 1", bus.IntReq); end
    tick();
    idle();
    checks++;
    if (bus.EPC_out !== 32'h0000_2000) begin errors++; $display("FAIL drop_epc: got %h want 00002000", bus.EPC_out); end
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_8000) begin errors++; $display("FAIL drop_cause: got %h want 00008000", d); end
    bus.EXLClr = 1'b1;
    tick();
    idle();
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0000) begin errors++; $display("FAIL ip_follow: got %h want 00000000", d); end
  endtask

  task automatic test_mtc0_regs();
    logic [31:0] d;
    idle();
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hDEAD_BEEC;
    tick();
    bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    tick();
    bus.A2 = 5'd15; bus.DIn = 32'h1234_5678;
    tick();
    idle();
    checks++;
    if (bus.EPC_out !== 32'hDEAD_BEEC) begin errors++; $display("FAIL epc_write: got %h want deadbeec", bus.EPC_out); end
    rd(5'd13, d); checks++;
    if (d !== 32'h0000_0000) begin errors++; $display("FAIL cause_ro: got %h want 00000000", d); end
    rd(5'd15, d); checks++;
    if (d !== 32'h0000_4D49) begin errors++; $display("FAIL prid_ro: got %h want 00004d49", d); end
  endtask

  task automatic test_reset_mid_handler();
    logic [31:0] d;
    idle();
    bus.error = 1'b1; bus.ExcCode_in = EXC_OV; bus.PC = 32'h0000_5000;
    tick();
    idle();
    rd(5'd12, d); checks++;
    if (d !== 32'h0000_FC03) begin errors++; $display("FAIL mid_sr_exl: got %h want 0000fc03", d); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(5'd12, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_sr: got %h want 0", d); end
    checks++;
    if (bus.EPC_out !== 32'h0) begin errors++; $display("FAIL mid_reset_epc: got %h want 0", bus.EPC_out); end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_priority();
    test_exlclr_write();
    test_drop_mtc0();
    test_mtc0_regs();
    test_reset_mid_handler();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
